// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants and types for the ALU issue sequencer and its register file.
package alu_op_sequencer_pkg;

    localparam int unsigned DEF_DATA_W = 4;
    localparam int unsigned DEF_NREGS  = 4;
    localparam int unsigned DEF_ADDR_W = 2;
    localparam int unsigned OP_W       = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'b000;
    localparam logic [OP_W-1:0] OP_OR   = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
    localparam logic [OP_W-1:0] OP_RSVD = 3'b011;
    localparam logic [OP_W-1:0] OP_ANDN = 3'b100;
    localparam logic [OP_W-1:0] OP_ORN  = 3'b101;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b110;
    localparam logic [OP_W-1:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

endpackage

// File: rtl/alu_regfile.sv
// Small register file: one synchronous write port, two operand read ports and
// a debug read port, all reads combinational; synchronous active-low clear.
module alu_regfile #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned NREGS  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign ra_data  = regs[ra_addr];
    assign rb_data  = regs[rb_addr];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for the 4-bit ALU: accepts one instruction per handshake, drives
// A/B/F from registers, writes Y back to the register file and strobes the result.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned NREGS  = DEF_NREGS,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic [ADDR_W-1:0] instr_rs,
    input  logic [ADDR_W-1:0] instr_rt,
    input  logic [DATA_W-1:0] instr_imm,
    input  logic              instr_use_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_f,
    input  logic [DATA_W-1:0] alu_y,
    output logic              result_valid,
    output logic [DATA_W-1:0] result_data,
    output logic              result_zero,
    output logic              illegal_op,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_e            state;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              wb_we_c;

    // Writeback happens at the edge that ends EXEC, while the ALU inputs are stable.
    assign wb_we_c = (state == ST_EXEC);

    alu_regfile #(
        .DATA_W(DATA_W),
        .NREGS (NREGS),
        .ADDR_W(ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wb_we_c),
        .waddr   (rd_q),
        .wdata   (alu_y),
        .ra_addr (instr_rs),
        .ra_data (rs_data),
        .rb_addr (instr_rt),
        .rb_data (rt_data),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_f        <= OP_AND;
            rd_q         <= '0;
            instr_ready  <= 1'b1;
            result_valid <= 1'b0;
            result_data  <= '0;
            result_zero  <= 1'b1;
            illegal_op   <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            illegal_op   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (instr_valid && instr_ready) begin
                        // Reserved opcode is flagged but never issued to the ALU.
                        if (instr_op == OP_RSVD) begin
                            illegal_op <= 1'b1;
                        end else begin
                            alu_a       <= rs_data;
                            alu_b       <= instr_use_imm ? instr_imm : rt_data;
                            alu_f       <= instr_op;
                            rd_q        <= instr_rd;
                            instr_ready <= 1'b0;
                            state       <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    result_data  <= alu_y;
                    result_zero  <= (alu_y == '0);
                    result_valid <= 1'b1;
                    state        <= ST_WB;
                end
                ST_WB: begin
                    instr_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    instr_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
